// File: rtl/lsu_seq_if.sv
// Bundle of decoder-side and memory-side signals for the load/store sequencer.
// The master modport is the sequencer itself; slave is its environment.
interface lsu_seq_if;
    logic        lw_en;
    logic        sw_en;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] ld_data;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        input  lw_en, sw_en, funct3, addr, wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output ld_data, stall, done, err
    );

    modport slave (
        output lw_en, sw_en, funct3, addr, wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  ld_data, stall, done, err
    );
endinterface

// File: rtl/lsu_seq.sv
// Single-outstanding load/store sequencer: aligns stores into byte lanes,
// extracts/extends loads, and aborts on misalignment or memory timeout.
module lsu_seq #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     rst,
    lsu_seq_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_e;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        we_q, we_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] ld_data_q, ld_data_d;

    logic        start;
    logic        misaligned;
    logic        timed_out;
    logic [1:0]  off;
    logic [31:0] rshift;
    logic [31:0] ld_ext;
    logic [3:0]  lane_mask;
    logic [31:0] lane_data;

    assign start = bus.lw_en | bus.sw_en;
    assign off   = addr_q[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (bus.funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.addr[0];
            2'b10:   misaligned = (bus.addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

    // Counter value seen here is the number of REQ/WAIT cycles already spent.
    assign timed_out = (cnt_q == CNT_LAST);

    always_comb begin
        rshift = bus.mem_rdata >> {off, 3'b000};
        ld_ext = rshift;
        case (funct3_q[1:0])
            2'b00:   ld_ext = funct3_q[2] ? {24'd0, rshift[7:0]}
                                          : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   ld_ext = funct3_q[2] ? {16'd0, rshift[15:0]}
                                          : {{16{rshift[15]}}, rshift[15:0]};
            default: ld_ext = rshift;
        endcase
    end

    always_comb begin
        lane_mask = 4'b1111;
        lane_data = wdata_q;
        case (funct3_q[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << off;
                lane_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << off;
                lane_data = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                lane_data = wdata_q;
            end
        endcase
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        funct3_d  = funct3_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        ld_data_d = ld_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (misaligned) begin
                        state_d = S_ERR;
                    end else begin
                        state_d  = S_REQ;
                        addr_d   = bus.addr;
                        wdata_d  = bus.wdata;
                        funct3_d = bus.funct3;
                        we_d     = ~bus.lw_en;
                        cnt_d    = 8'd0;
                    end
                end
            end
            S_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.mem_gnt) begin
                    state_d = we_q ? S_DONE : S_WAIT;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.mem_rvalid) begin
                    state_d   = S_DONE;
                    ld_data_d = ld_ext;
                end else if (timed_out) begin
                    state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            funct3_q  <= '0;
            we_q      <= 1'b0;
            cnt_q     <= '0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            funct3_q  <= funct3_d;
            we_q      <= we_d;
            cnt_q     <= cnt_d;
            ld_data_q <= ld_data_d;
        end
    end

    // Write-side signals are forced quiet outside a store request.
    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_we    = bus.mem_req & we_q;
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign bus.mem_wmask = bus.mem_we ? lane_mask : 4'b0000;
    assign bus.mem_wdata = bus.mem_we ? lane_data : 32'd0;
    assign bus.ld_data   = ld_data_q;
    assign bus.done      = (state_q == S_DONE);
    assign bus.err       = (state_q == S_ERR);
    assign bus.stall     = ((state_q == S_IDLE) & start) |
                           (state_q == S_REQ) | (state_q == S_WAIT);

endmodule

// File: tb/tb_lsu_seq.sv
// Directed bench for lsu_seq: loads, stores, misalignment, timeout and
// mid-transaction reset, with hand-computed expectations.
module tb_lsu_seq;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    lsu_seq_if bus ();

    lsu_seq #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus.lw_en      = 1'b0;
        bus.sw_en      = 1'b0;
        bus.funct3     = 3'b000;
        bus.addr       = 32'h0;
        bus.wdata      = 32'h0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        settle();
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_ld_data", bus.ld_data, 32'h0);
        check("rst_stall", 32'(bus.stall), 32'd0);

        // Signed byte load from the top lane, zero-wait memory
        bus.lw_en = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h0000_1003;
        settle();
        check("lb_stall_c0", 32'(bus.stall), 32'd1);
        step();
        idle_inputs();
        bus.addr    = 32'hDEAD_BEEF;
        bus.mem_gnt = 1'b1;
        settle();
        check("lb_req_c1", 32'(bus.mem_req), 32'd1);
        check("lb_addr", bus.mem_addr, 32'h0000_1000);
        check("lb_we", 32'(bus.mem_we), 32'd0);
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_FF00;
        settle();
        check("lb_req_c2", 32'(bus.mem_req), 32'd0);
        check("lb_stall_c2", 32'(bus.stall), 32'd1);
        step();
        idle_inputs();
        settle();
        check("lb_done_c3", 32'(bus.done), 32'd1);
        check("lb_stall_c3", 32'(bus.stall), 32'd0);
        check("lb_ld_data", bus.ld_data, 32'hFFFF_FF80);
        step();
        check("lb_done_c4", 32'(bus.done), 32'd0);

        // Halfword store to upper half, grant on third request cycle
        bus.sw_en = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h0000_2002;
        bus.wdata = 32'h1234_ABCD;
        settle();
        check("sh_stall_c0", 32'(bus.stall), 32'd1);
        step();
        idle_inputs();
        settle();
        check("sh_req_1", 32'(bus.mem_req), 32'd1);
        check("sh_we", 32'(bus.mem_we), 32'd1);
        check("sh_wmask", 32'(bus.mem_wmask), 32'b1100);
        check("sh_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        check("sh_addr", bus.mem_addr, 32'h0000_2000);
        step();
        check("sh_req_2", 32'(bus.mem_req), 32'd1);
        check("sh_wmask_2", 32'(bus.mem_wmask), 32'b1100);
        step();
        bus.mem_gnt = 1'b1;
        settle();
        check("sh_req_3", 32'(bus.mem_req), 32'd1);
        step();
        idle_inputs();
        settle();
        check("sh_done", 32'(bus.done), 32'd1);
        check("sh_req_off", 32'(bus.mem_req), 32'd0);
        check("sh_wmask_off", 32'(bus.mem_wmask), 32'd0);
        check("sh_wdata_off", bus.mem_wdata, 32'h0);
        check("sh_we_off", 32'(bus.mem_we), 32'd0);
        check("sh_ld_hold", bus.ld_data, 32'hFFFF_FF80);
        step();

        // Misaligned word load
        bus.lw_en = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0000_3001;
        settle();
        check("mis_stall", 32'(bus.stall), 32'd1);
        step();
        idle_inputs();
        settle();
        check("mis_err", 32'(bus.err), 32'd1);
        check("mis_req", 32'(bus.mem_req), 32'd0);
        check("mis_stall_off", 32'(bus.stall), 32'd0);
        check("mis_done", 32'(bus.done), 32'd0);
        step();
        check("mis_err_off", 32'(bus.err), 32'd0);

        // Timeout: load granted, rvalid never returns
        bus.lw_en = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0000_4000;
        settle();
        step();
        idle_inputs();
        bus.mem_gnt = 1'b1;
        settle();
        step();
        bus.mem_gnt = 1'b0;
        settle();
        step();
        step();
        check("to_err_early", 32'(bus.err), 32'd0);
        check("to_stall_4", 32'(bus.stall), 32'd1);
        step();
        check("to_err", 32'(bus.err), 32'd1);
        check("to_done", 32'(bus.done), 32'd0);
        step();
        check("to_err_off", 32'(bus.err), 32'd0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1234_5678;
        settle();
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        check("to_stray_ld", bus.ld_data, 32'hFFFF_FF80);
        check("to_stray_done", 32'(bus.done), 32'd0);

        // Both enables: load wins, unsigned byte from lane 1
        bus.lw_en = 1'b1; bus.sw_en = 1'b1; bus.funct3 = 3'b100; bus.addr = 32'h0000_0011;
        settle();
        step();
        idle_inputs();
        bus.mem_gnt = 1'b1;
        settle();
        check("both_we", 32'(bus.mem_we), 32'd0);
        check("both_addr", bus.mem_addr, 32'h0000_0010);
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000_F500;
        settle();
        step();
        idle_inputs();
        settle();
        check("both_done", 32'(bus.done), 32'd1);
        check("both_ld", bus.ld_data, 32'h0000_00F5);
        step();

        // Signed halfword load from upper half
        bus.lw_en = 1'b1; bus.funct3 = 3'b001; bus.addr = 32'h0000_6002;
        settle();
        step();
        idle_inputs();
        bus.mem_gnt = 1'b1;
        settle();
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h8001_1234;
        settle();
        step();
        idle_inputs();
        settle();
        check("lh_ld", bus.ld_data, 32'hFFFF_8001);
        step();

        // Byte store; grant arrives in the same cycle the counter expires
        bus.sw_en = 1'b1; bus.funct3 = 3'b000; bus.addr = 32'h0000_5001;
        bus.wdata = 32'hFFFF_FFA5;
        settle();
        step();
        idle_inputs();
        settle();
        check("sb_wmask", 32'(bus.mem_wmask), 32'b0010);
        check("sb_wdata", bus.mem_wdata, 32'hA5A5_A5A5);
        step();
        step();
        step();
        bus.mem_gnt = 1'b1;
        settle();
        check("tie_req_4", 32'(bus.mem_req), 32'd1);
        step();
        idle_inputs();
        settle();
        check("tie_done", 32'(bus.done), 32'd1);
        check("tie_err", 32'(bus.err), 32'd0);
        step();

        // Reset while waiting for read data
        bus.lw_en = 1'b1; bus.funct3 = 3'b010; bus.addr = 32'h0000_7000;
        settle();
        step();
        idle_inputs();
        bus.mem_gnt = 1'b1;
        settle();
        step();
        bus.mem_gnt = 1'b0;
        rst = 1'b1;
        settle();
        step();
        rst = 1'b0;
        settle();
        check("rw_req", 32'(bus.mem_req), 32'd0);
        check("rw_stall", 32'(bus.stall), 32'd0);
        check("rw_done", 32'(bus.done), 32'd0);
        check("rw_ld_clr", bus.ld_data, 32'h0);
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        settle();
        step();
        bus.mem_rvalid = 1'b0;
        settle();
        check("rw_late_done", 32'(bus.done), 32'd0);
        check("rw_late_ld", bus.ld_data, 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
